// File: rtl/div_iter_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : div_iter_unit_if
// Brief   : EX-stage <-> iterative divider handshake and operand bundle.
// Revision: 1.0
// ============================================================================
interface div_iter_unit_if #(
  parameter int DATA_W = 32
);
  logic                  div_start;
  logic                  div_sign;
  logic [DATA_W-1:0]     dividend;
  logic [DATA_W-1:0]     divisor;
  logic                  flush;
  logic                  post_allowin;
  logic                  div_stall;
  logic                  div_done;
  logic [2*DATA_W-1:0]   div_res;

  modport master (
    output div_start, div_sign, dividend, divisor, flush, post_allowin,
    input  div_stall, div_done, div_res
  );

  modport slave (
    input  div_start, div_sign, dividend, divisor, flush, post_allowin,
    output div_stall, div_done, div_res
  );
endinterface
`default_nettype wire

// File: rtl/div_iter_unit.sv
`default_nettype none
// ============================================================================
// Module  : div_iter_unit
// Brief   : Radix-2 restoring DIV/DIVU, one quotient bit per cycle, result
//           packed {remainder, quotient}. DIV_EARLY_OUT_EN enables the
//           single-cycle path for divisor==0 or |dividend|<|divisor|.
// Revision: 1.0
// ============================================================================
module div_iter_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic             clk,
  input  logic             reset,
  div_iter_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DATA_W - 1);

  state_t                r_state;
  state_t                w_state_nx;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_W-1:0]     r_rem;
  logic [DATA_W-1:0]     r_quo;
  logic [DATA_W-1:0]     r_dvs;
  logic                  r_q_neg;
  logic                  r_r_neg;
  logic [2*DATA_W-1:0]   r_res;

  logic                  w_accept;
  logic                  w_last;
  logic                  w_dvz;
  logic                  w_a_neg;
  logic                  w_b_neg;
  logic [DATA_W-1:0]     w_abs_a;
  logic [DATA_W-1:0]     w_abs_b;
  logic [DATA_W:0]       w_part;
  logic [DATA_W+1:0]     w_diff;
  logic [DATA_W-1:0]     w_rem_nx;
  logic [DATA_W-1:0]     w_quo_nx;
  logic [DATA_W-1:0]     w_rem_fix;
  logic [DATA_W-1:0]     w_quo_fix;

  assign w_accept = (r_state == S_IDLE) && bus.div_start && !bus.flush;
  assign w_last   = (r_cnt == c_LAST);
  assign w_dvz    = (bus.divisor == '0);
  assign w_a_neg  = bus.div_sign && bus.dividend[DATA_W-1];
  assign w_b_neg  = bus.div_sign && bus.divisor[DATA_W-1];
  assign w_abs_a  = w_a_neg ? -bus.dividend : bus.dividend;
  assign w_abs_b  = w_b_neg ? -bus.divisor  : bus.divisor;

  // The partial remainder needs one extra bit after the shift; a second
  // extra bit carries the borrow of the trial subtraction.
  assign w_part   = {r_rem, r_quo[DATA_W-1]};
  assign w_diff   = {1'b0, w_part} - {2'b00, r_dvs};
  assign w_rem_nx = w_diff[DATA_W+1] ? w_part[DATA_W-1:0] : w_diff[DATA_W-1:0];
  assign w_quo_nx = {r_quo[DATA_W-2:0], ~w_diff[DATA_W+1]};
  assign w_rem_fix = r_r_neg ? -w_rem_nx : w_rem_nx;
  assign w_quo_fix = r_q_neg ? -w_quo_nx : w_quo_nx;

`ifdef DIV_EARLY_OUT_EN
  logic w_early;
  assign w_early = w_dvz || (w_abs_a < w_abs_b);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
`ifdef DIV_EARLY_OUT_EN
          w_state_nx = w_early ? S_DONE : S_CALC;
`else
          w_state_nx = S_CALC;
`endif
        end
      end
      S_CALC: begin
        if (bus.flush) begin
          w_state_nx = S_IDLE;
        end else if (w_last) begin
          w_state_nx = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.post_allowin || bus.flush) begin
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // A zero divisor latches the raw dividend and clears both negate flags, so
  // the iteration naturally yields quotient all ones and remainder = dividend.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
      r_res   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= w_dvz ? bus.dividend : w_abs_a;
            r_dvs   <= w_abs_b;
            r_q_neg <= !w_dvz && (w_a_neg ^ w_b_neg);
            r_r_neg <= !w_dvz && w_a_neg;
`ifdef DIV_EARLY_OUT_EN
            if (w_early) begin
              r_res <= {bus.dividend, (w_dvz ? {DATA_W{1'b1}} : {DATA_W{1'b0}})};
            end
`endif
          end
        end
        S_CALC: begin
          if (!bus.flush) begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_res <= {w_rem_fix, w_quo_fix};
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.div_stall = w_accept || (r_state == S_CALC);
  assign bus.div_done  = (r_state == S_DONE);
  assign bus.div_res   = r_res;

endmodule
`default_nettype wire

// File: tb/tb_div_iter_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_div_iter_unit
// Brief   : Self-checking bench for div_iter_unit against an arithmetic model.
// Revision: 1.0
// ============================================================================
module tb_div_iter_unit;

  localparam int c_W = 32;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;

  div_iter_unit_if #(.DATA_W(c_W)) intf ();

  div_iter_unit #(.DATA_W(c_W), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (intf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic longint mag(input bit s, input logic [31:0] x);
    longint v;
    v = s ? longint'($signed(x)) : longint'({32'b0, x});
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFFFFFF};
    sa = s ? longint'($signed(a)) : longint'({32'b0, a});
    sb = s ? longint'($signed(b)) : longint'({32'b0, b});
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int ref_lat(input bit s, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
    if (b == 32'd0 || mag(s, a) < mag(s, b)) return 1;
`else
    if (mag(s, a) < 0 || mag(s, b) < 0) return -1;
`endif
    return c_W + 1;
  endfunction

  task automatic run_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                         input string tag, input int hold);
    logic [63:0] exp;
    logic [63:0] snap;
    int lat, cyc, stl;
    bit bad;
    exp = ref_div(s, a, b);
    lat = ref_lat(s, a, b);
    @(negedge clk);
    intf.div_start = 1'b1;
    intf.div_sign  = s;
    intf.dividend  = a;
    intf.divisor   = b;
    #1;
    cyc = 0;
    stl = 0;
    while (!intf.div_done && cyc < 100) begin
      if (intf.div_stall) stl++;
      @(negedge clk);
      #1;
      cyc++;
    end
    check({tag, " res"},   intf.div_res, exp);
    check({tag, " lat"},   64'(cyc), 64'(lat));
    check({tag, " stall"}, 64'(stl), 64'(lat));
    if (hold > 0) begin
      bad  = 1'b0;
      snap = intf.div_res;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        #1;
        if (!intf.div_done || intf.div_stall || intf.div_res !== snap) bad = 1'b1;
      end
      check({tag, " hold"}, 64'(bad), 64'd0);
    end
    intf.post_allowin = 1'b1;
    intf.div_start    = 1'b0;
    @(negedge clk);
    #1;
    check({tag, " release"}, {62'd0, intf.div_done, intf.div_stall}, 64'd0);
    intf.post_allowin = 1'b0;
  endtask

  initial begin
    bit          s;
    logic [31:0] a, b;
    int          mode;
    bit          bad;
    n_chk = 0;
    n_err = 0;
    reset             = 1'b1;
    intf.div_start    = 1'b0;
    intf.div_sign     = 1'b0;
    intf.dividend     = '0;
    intf.divisor      = '0;
    intf.flush        = 1'b0;
    intf.post_allowin = 1'b0;
    repeat (3) @(negedge clk);
    check("reset outs", {intf.div_res[61:0], intf.div_done, intf.div_stall}, 64'd0);
    reset = 1'b0;

    run_div(1'b0, 32'd100, 32'd7, "divu 100/7", 0);
    run_div(1'b1, -32'sd7, 32'd2, "div -7/2", 0);
    run_div(1'b1, 32'd7, -32'sd2, "div 7/-2", 0);
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, "div ovf", 0);
    run_div(1'b0, 32'd5, 32'd0, "divu 5/0", 0);
    run_div(1'b0, 32'd3, 32'd9, "divu 3/9", 0);
    run_div(1'b1, 32'd1000, 32'd3, "hold", 5);

    // Flush partway through CALC, then a fresh divide must still be correct.
    @(negedge clk);
    intf.div_start = 1'b1;
    intf.div_sign  = 1'b0;
    intf.dividend  = 32'd1000;
    intf.divisor   = 32'd3;
    repeat (11) @(negedge clk);
    intf.flush     = 1'b1;
    intf.div_start = 1'b0;
    @(negedge clk);
    #1;
    intf.flush = 1'b0;
    check("flush stall", {62'd0, intf.div_done, intf.div_stall}, 64'd0);
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (intf.div_done || intf.div_stall) bad = 1'b1;
    end
    check("flush quiet", 64'(bad), 64'd0);
    run_div(1'b0, 32'd9, 32'd3, "divu 9/3", 0);

    // Async reset mid-CALC clears everything without waiting for an edge.
    @(negedge clk);
    intf.div_start = 1'b1;
    intf.dividend  = 32'd5000;
    intf.divisor   = 32'd7;
    repeat (6) @(negedge clk);
    #1;
    reset          = 1'b1;
    intf.div_start = 1'b0;
    #1;
    check("async reset", {intf.div_res[61:0], intf.div_done, intf.div_stall}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int n = 0; n < 40; n++) begin
      s    = 1'($urandom_range(0, 1));
      a    = $urandom;
      mode = $urandom_range(0, 3);
      case (mode)
        0:       b = $urandom;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'd0;
        default: b = a + 32'($urandom_range(1, 255));
      endcase
      if (s && mode == 1 && $urandom_range(0, 1) == 1) b = -b;
      run_div(s, a, b, $sformatf("rnd%0d", n), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
